// File: rtl/alu_pkg.sv
// alu_pkg: operation codes and FSM state type shared by the ALU decoder and control
package alu_pkg;
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: unsigned shift-add multiplier, one bit per cycle; ports clk, rst_n, start, a, b in, done (last step this cycle), product (low WIDTH bits) out; built only with ALU_MUL_EN
`ifdef ALU_MUL_EN
module alu_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH + 1);
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] acc, mc, mp;
  logic busy;
  assign product = acc + (mp[0] ? mc : '0);
  assign done = busy && cnt == CW'(WIDTH - 1);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy <= 1'b0;
      cnt <= '0;
      acc <= '0;
      mc <= '0;
      mp <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt <= '0;
      acc <= '0;
      mc <= a;
      mp <= b;
    end else if (busy) begin
      busy <= !done;
      cnt <= cnt + 1'b1;
      acc <= product;
      mc <= mc << 1;
      mp <= mp >> 1;
    end
  end
endmodule
`endif

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: handshaked ALU (add/sub/and/or/slt, optional multi-cycle mul under ALU_MUL_EN); ports clk, rst_n, in_valid/in_ready, alu_control, src_a, src_b, out_valid/out_ready, result, zero
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
);
  state_t state, state_nx;
  logic accept, is_mul, mul_done;
  logic [WIDTH-1:0] alu_res, mul_res;
  assign in_ready = rst_n && (state == IDLE || (state == DONE && out_ready));
  assign accept = in_valid && in_ready;
  assign out_valid = state == DONE;
  assign zero = result == '0;
`ifdef ALU_MUL_EN
  assign is_mul = alu_control == OP_MUL;
  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk(clk),
    .rst_n(rst_n),
    .start(accept && is_mul),
    .a(src_a),
    .b(src_b),
    .done(mul_done),
    .product(mul_res)
  );
`else
  assign is_mul = 1'b0;
  assign mul_done = 1'b0;
  assign mul_res = '0;
`endif
  always_comb begin
    alu_res = alu_control == OP_ADD ? src_a + src_b :
              alu_control == OP_SUB ? src_a - src_b :
              alu_control == OP_AND ? src_a & src_b :
              alu_control == OP_OR  ? src_a | src_b :
              alu_control == OP_SLT ? WIDTH'($signed(src_a) < $signed(src_b)) : '0;
  end
  always_comb begin
    state_nx = state;
    state_nx = accept ? (is_mul ? BUSY : DONE) :
               (state == BUSY && mul_done) ? DONE :
               (state == DONE && out_ready) ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      result <= '0;
    end else begin
      state <= state_nx;
      if (accept && !is_mul) result <= alu_res;
      else if (mul_done) result <= mul_res;
    end
  end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed vectors with a scoreboard queue checked by a decoupled output monitor
module tb_alu_exec_unit;
  import alu_pkg::*;
  localparam int W = 32;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 1;
  logic in_ready, out_valid, zero;
  logic [2:0] alu_control = '0;
  logic [W-1:0] src_a = '0, src_b = '0, result;
  int compared = 0, mismatched = 0, cyc = 0;
  typedef struct {logic [W-1:0] res; int at;} exp_t;
  exp_t q[$];
  exp_t e;

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_control(alu_control), .src_a(src_a), .src_b(src_b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .zero(zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (q.size() == 0) chk("spurious_out_valid", out_valid, 0);
      else if (out_ready) begin
        e = q.pop_front();
        chk("result", result, e.res);
        chk("zero", zero, e.res == '0);
        chk("out_cycle", cyc, e.at);
      end else begin
        chk("stall_result", result, q[0].res);
        chk("stall_in_ready", in_ready, 0);
      end
    end
  end

  task automatic send(logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b, logic [W-1:0] r, int lat, bit push);
    int n = 0;
    alu_control = op; src_a = a; src_b = b; in_valid = 1;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("accept_timeout", in_ready, 1);
    else if (push) q.push_back('{r, cyc + lat});
    @(posedge clk);
    #1 in_valid = 0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_zero", zero, 1);
    @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    send(OP_ADD, 32'hFFFF_FFFF, 32'h1, 32'h0, 1, 1);
    send(OP_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE, 1, 1);
    send(OP_SLT, 32'hFFFF_FFFF, 32'h1, 32'h1, 1, 1);
    send(OP_SLT, 32'h1, 32'hFFFF_FFFF, 32'h0, 1, 1);
    repeat (2) @(posedge clk);
    #1 out_ready = 0;
    send(OP_ADD, 32'd3, 32'd4, 32'd7, 4, 1);
    alu_control = OP_OR; src_a = 32'h5; src_b = 32'hA; in_valid = 1;
    repeat (3) @(posedge clk);
    #1 out_ready = 1;
    send(OP_OR, 32'h5, 32'hA, 32'hF, 1, 1);
    repeat (2) @(posedge clk);
    #1;
    send(OP_AND, 32'hF0F0, 32'hFF00, 32'hF000, 1, 1);
    send(OP_OR, 32'hF0F0, 32'h0F0F, 32'hFFFF, 1, 1);
    send(OP_ADD, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1, 1);
    send(OP_SLT, 32'd3, 32'd5, 32'h1, 1, 1);
    repeat (2) @(posedge clk);
    #1;
    send(3'b110, 32'd9, 32'd9, 32'h0, 1, 1);
`ifdef ALU_MUL_EN
    send(OP_MUL, 32'h0001_0000, 32'h0001_0003, 32'h0003_0000, 33, 1);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      chk("busy_in_ready", in_ready, 0);
    end
    repeat (3) @(posedge clk);
    #1;
    send(OP_MUL, 32'd6, 32'd7, 32'd42, 33, 0);
    repeat (9) @(posedge clk);
    #1 rst_n = 0;
    @(negedge clk);
    chk("rst_mul_in_ready", in_ready, 0);
    @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk("post_rst_out_valid", out_valid, 0);
    chk("post_rst_result", result, 0);
    chk("post_rst_zero", zero, 1);
    chk("post_rst_in_ready", in_ready, 1);
    repeat (40) @(negedge clk);
    chk("post_rst_no_result", out_valid, 0);
`else
    send(OP_MUL, 32'd6, 32'd7, 32'h0, 1, 1);
    send(3'b111, 32'hFFFF_FFFF, 32'h1, 32'h0, 1, 1);
`endif
    repeat (4) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
